// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_sram_slave
// Brief    : AXI3 slave memory responder backed by a word-addressed RAM.
//            Independent read and write state machines, so one read burst
//            and one write burst may be in flight at the same time.
//            Optional macro AXI_SLV_READ_LAT_EN inserts READ_LAT wait cycles
//            between the AR handshake and the first R beat.
// Revision : 1.0 - initial release
// ============================================================================
module axi_sram_slave #(
    parameter int MEM_AW   = 16,
    parameter int READ_LAT = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    // read address channel
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    // read data channel
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // write address channel
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    // write data channel
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response channel
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [1:0] c_R_IDLE = 2'd0;
    localparam logic [1:0] c_R_WAIT = 2'd1;
    localparam logic [1:0] c_R_DATA = 2'd2;

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_DATA = 2'd1;
    localparam logic [1:0] c_W_RESP = 2'd2;

`ifdef AXI_SLV_READ_LAT_EN
    // A zero latency collapses to the direct path into R_DATA.
    localparam logic [1:0] c_R_FIRST = (READ_LAT == 0) ? c_R_DATA : c_R_WAIT;
`else
    localparam logic [1:0] c_R_FIRST = c_R_DATA;
    localparam int         c_unused_lat = READ_LAT;
`endif

    // Lock/cache/prot and the write id carry no meaning for a plain RAM.
    logic w_unused_sig;
    assign w_unused_sig = &{1'b0, arlock, arcache, arprot, awlock, awcache, awprot, wid};

    // FIXED holds the address; INCR and WRAP both advance by the beat size.
    function automatic logic [31:0] f_step(input logic [31:0] a, input logic [2:0] s,
                                           input logic [1:0] b);
        return (b == 2'b00) ? a : a + (32'd1 << s);
    endfunction

    logic [31:0] r_mem [0:(2**MEM_AW)-1];

    // ------------------------------------------------------------------ read
    logic [1:0]  r_rd_state, w_rd_state_next;
    logic        r_rst_done;
    logic [3:0]  r_rd_id;
    logic [31:0] r_rd_addr;
    logic [7:0]  r_rd_len, r_rd_cnt;
    logic [2:0]  r_rd_size;
    logic [1:0]  r_rd_burst;
    logic [31:0] r_rdata;
    logic        w_ar_hs, w_r_hs, w_rd_last, w_lat_done;
    logic        w_rd_load;
    logic [31:0] w_rd_load_addr;
    logic [MEM_AW-1:0] w_rd_idx;

    assign w_ar_hs   = arvalid & arready;
    assign w_r_hs    = rvalid & rready;
    assign w_rd_last = (r_rd_cnt == r_rd_len);
    assign w_rd_idx  = w_rd_load_addr[MEM_AW+1:2];

`ifdef AXI_SLV_READ_LAT_EN
    logic [7:0] r_lat_cnt;
    assign w_lat_done = (r_lat_cnt == 8'(READ_LAT - 1));

    // Wait-cycle counter, restarted on every accepted read address.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                     r_lat_cnt <= 8'd0;
        else if (w_ar_hs)                 r_lat_cnt <= 8'd0;
        else if (r_rd_state == c_R_WAIT)  r_lat_cnt <= r_lat_cnt + 8'd1;
    end
`else
    assign w_lat_done = 1'b1;
`endif

    // Read state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_rd_state <= c_R_IDLE;
        else          r_rd_state <= w_rd_state_next;
    end

    // Read next-state logic.
    always_comb begin
        w_rd_state_next = r_rd_state;
        case (r_rd_state)
            c_R_IDLE: if (w_ar_hs)              w_rd_state_next = c_R_FIRST;
            c_R_WAIT: if (w_lat_done)           w_rd_state_next = c_R_DATA;
            c_R_DATA: if (w_r_hs && w_rd_last)  w_rd_state_next = c_R_IDLE;
            default:                            w_rd_state_next = c_R_IDLE;
        endcase
    end

    // Read channel outputs and the RAM read-port request.
    always_comb begin
        arready        = (r_rd_state == c_R_IDLE) && r_rst_done;
        rvalid         = (r_rd_state == c_R_DATA);
        rlast          = rvalid && w_rd_last;
        w_rd_load      = 1'b0;
        w_rd_load_addr = r_rd_addr;
        if (w_ar_hs && (c_R_FIRST == c_R_DATA)) begin
            w_rd_load      = 1'b1;
            w_rd_load_addr = araddr;
        end else if ((r_rd_state == c_R_WAIT) && w_lat_done) begin
            w_rd_load      = 1'b1;
        end else if (w_r_hs && !w_rd_last) begin
            w_rd_load      = 1'b1;
            w_rd_load_addr = f_step(r_rd_addr, r_rd_size, r_rd_burst);
        end
    end

    // Read burst context and registered read data; rdata only changes on a load,
    // so it stays stable while the master stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rst_done <= 1'b0;
            r_rd_id    <= 4'd0;
            r_rd_addr  <= 32'd0;
            r_rd_len   <= 8'd0;
            r_rd_cnt   <= 8'd0;
            r_rd_size  <= 3'd0;
            r_rd_burst <= 2'd0;
            r_rdata    <= 32'd0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_ar_hs) begin
                r_rd_id    <= arid;
                r_rd_addr  <= araddr;
                r_rd_len   <= arlen;
                r_rd_size  <= arsize;
                r_rd_burst <= arburst;
                r_rd_cnt   <= 8'd0;
            end else if (w_r_hs && !w_rd_last) begin
                r_rd_addr  <= f_step(r_rd_addr, r_rd_size, r_rd_burst);
                r_rd_cnt   <= r_rd_cnt + 8'd1;
            end
            if (w_rd_load) r_rdata <= r_mem[w_rd_idx];
        end
    end

    assign rid   = r_rd_id;
    assign rdata = r_rdata;
    assign rresp = 2'b00;

    // ----------------------------------------------------------------- write
    logic [1:0]  r_wr_state, w_wr_state_next;
    logic [3:0]  r_wr_id;
    logic [31:0] r_wr_addr;
    logic [7:0]  r_wr_len, r_wr_cnt;
    logic [2:0]  r_wr_size;
    logic [1:0]  r_wr_burst;
    logic        r_wr_err;
    logic        w_aw_hs, w_w_hs, w_b_hs, w_wr_last;
    logic [MEM_AW-1:0] w_wr_idx;

    assign w_aw_hs   = awvalid & awready;
    assign w_w_hs    = wvalid & wready;
    assign w_b_hs    = bvalid & bready;
    assign w_wr_last = (r_wr_cnt == r_wr_len);
    assign w_wr_idx  = r_wr_addr[MEM_AW+1:2];

    // Write state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_wr_state <= c_W_IDLE;
        else          r_wr_state <= w_wr_state_next;
    end

    // Write next-state logic; the beat count, not wlast, ends the burst.
    always_comb begin
        w_wr_state_next = r_wr_state;
        case (r_wr_state)
            c_W_IDLE: if (w_aw_hs)              w_wr_state_next = c_W_DATA;
            c_W_DATA: if (w_w_hs && w_wr_last)  w_wr_state_next = c_W_RESP;
            c_W_RESP: if (w_b_hs)               w_wr_state_next = c_W_IDLE;
            default:                            w_wr_state_next = c_W_IDLE;
        endcase
    end

    // Write channel outputs.
    always_comb begin
        awready = (r_wr_state == c_W_IDLE) && r_rst_done;
        wready  = (r_wr_state == c_W_DATA);
        bvalid  = (r_wr_state == c_W_RESP);
        bresp   = r_wr_err ? 2'b10 : 2'b00;
    end

    // Write burst context and the wlast-consistency error flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_id    <= 4'd0;
            r_wr_addr  <= 32'd0;
            r_wr_len   <= 8'd0;
            r_wr_cnt   <= 8'd0;
            r_wr_size  <= 3'd0;
            r_wr_burst <= 2'd0;
            r_wr_err   <= 1'b0;
        end else if (w_aw_hs) begin
            r_wr_id    <= awid;
            r_wr_addr  <= awaddr;
            r_wr_len   <= awlen;
            r_wr_size  <= awsize;
            r_wr_burst <= awburst;
            r_wr_cnt   <= 8'd0;
            r_wr_err   <= 1'b0;
        end else if (w_w_hs) begin
            r_wr_addr  <= f_step(r_wr_addr, r_wr_size, r_wr_burst);
            r_wr_cnt   <= r_wr_cnt + 8'd1;
            if (wlast != w_wr_last) r_wr_err <= 1'b1;
        end
    end

    // RAM write port with byte-lane enables; contents survive reset.
    always_ff @(posedge aclk) begin
        if (w_w_hs) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) r_mem[w_wr_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign bid = r_wr_id;

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_sram_slave
// Brief    : Directed self-checking bench for axi_sram_slave (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;

    logic        aclk, aresetn;
    logic [3:0]  arid;    logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
    logic [1:0]  arburst; logic [1:0]  arlock; logic [3:0] arcache; logic [2:0] arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;     logic [31:0] rdata;  logic [1:0] rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;    logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
    logic [1:0]  awburst; logic [1:0]  awlock; logic [3:0] awcache; logic [2:0] awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;     logic [31:0] wdata;  logic [3:0] wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;     logic [1:0]  bresp;
    logic        bvalid, bready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wbuf [0:15];
    logic [3:0]  sbuf [0:15];
    logic [31:0] rbuf [0:15];
    logic        lbuf [0:15];

    axi_sram_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Write burst (size 4 bytes, INCR) from wbuf/sbuf; lastmask bit b drives wlast on beat b.
    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [15:0] lastmask, output logic [1:0] resp,
                             output logic [3:0] got_bid, output logic b_prompt);
        int k;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        k = 0;
        while (!awready && k < 50) begin step(); k++; end
        if (!awready) check_value("aw_timeout", {31'd0, awready}, 32'd1);
        step();
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wbuf[b]; wstrb = sbuf[b]; wlast = lastmask[b]; wvalid = 1'b1;
            k = 0;
            while (!wready && k < 50) begin step(); k++; end
            if (!wready) check_value("w_timeout", {31'd0, wready}, 32'd1);
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
        b_prompt = bvalid;
        bready = 1'b1;
        k = 0;
        while (!bvalid && k < 50) begin step(); k++; end
        if (!bvalid) check_value("b_timeout", {31'd0, bvalid}, 32'd1);
        resp = bresp; got_bid = bid;
        step();
        bready = 1'b0;
    endtask

    // Read burst (size 4 bytes) into rbuf/lbuf; rready follows rpat[cycle % 4].
    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] rpat,
                            output logic [3:0] got_rid, output int beats);
        int k, cyc;
        logic        stalled;
        logic [31:0] held_d;
        logic        held_l;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        k = 0;
        while (!arready && k < 50) begin step(); k++; end
        if (!arready) check_value("ar_timeout", {31'd0, arready}, 32'd1);
        step();
        arvalid = 1'b0;
        check_value("r_latency", {31'd0, rvalid}, 32'd1);
        beats = 0; cyc = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0; got_rid = '0;
        while (beats <= int'(len) && cyc < 200) begin
            rready = rpat[cyc % 4];
            if (rvalid) begin
                if (stalled) begin
                    check_value("r_stable_data", rdata, held_d);
                    check_value("r_stable_last", {31'd0, rlast}, {31'd0, held_l});
                end
                if (rready) begin
                    rbuf[beats] = rdata; lbuf[beats] = rlast; got_rid = rid;
                    beats++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1; held_d = rdata; held_l = rlast;
                end
            end
            step();
            cyc++;
        end
        rready = 1'b0;
        check_value("r_done_rvalid", {31'd0, rvalid}, 32'd0);
        check_value("r_done_arready", {31'd0, arready}, 32'd1);
    endtask

    logic [1:0] resp;
    logic [3:0] gid;
    logic       bp;
    int         nb;

    initial begin
        aresetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0;
        arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0;
        awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;

        // Reset values
        check_value("rst_arready", {31'd0, arready}, 32'd0);
        check_value("rst_awready", {31'd0, awready}, 32'd0);
        check_value("rst_wready",  {31'd0, wready},  32'd0);
        check_value("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check_value("rst_rlast",   {31'd0, rlast},   32'd0);
        check_value("rst_rdata",   rdata,            32'd0);
        check_value("rst_rid",     {28'd0, rid},     32'd0);
        check_value("rst_rresp",   {30'd0, rresp},   32'd0);
        check_value("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check_value("rst_bid",     {28'd0, bid},     32'd0);
        check_value("rst_bresp",   {30'd0, bresp},   32'd0);
        aresetn = 1'b1;
        step();
        check_value("post_rst_arready", {31'd0, arready}, 32'd1);
        check_value("post_rst_awready", {31'd0, awready}, 32'd1);

        // 4-beat INCR write then read-back
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
        axi_write(4'h5, 32'h1C00_0100, 8'd3, 16'h0008, resp, gid, bp);
        check_value("wr1_bresp", {30'd0, resp}, 32'd0);
        check_value("wr1_bid", {28'd0, gid}, 32'h5);
        check_value("wr1_b_prompt", {31'd0, bp}, 32'd1);
        axi_read(4'h2, 32'h1C00_0100, 8'd3, 2'b01, 4'b1111, gid, nb);
        check_value("rd1_beats", nb, 32'd4);
        check_value("rd1_rid", {28'd0, gid}, 32'h2);
        for (int i = 0; i < 4; i++) begin
            check_value($sformatf("rd1_data%0d", i), rbuf[i], 32'h11 * (i + 1));
            check_value($sformatf("rd1_last%0d", i), {31'd0, lbuf[i]}, (i == 3) ? 32'd1 : 32'd0);
        end

        // FIXED burst repeats the same word
        axi_read(4'h4, 32'h1C00_0104, 8'd1, 2'b00, 4'b1111, gid, nb);
        check_value("fixed_beats", nb, 32'd2);
        check_value("fixed_d0", rbuf[0], 32'h22);
        check_value("fixed_d1", rbuf[1], 32'h22);

        // Partial byte-lane write over a zeroed word
        wbuf[0] = 32'h0; sbuf[0] = 4'hF;
        axi_write(4'h1, 32'h0000_0200, 8'd0, 16'h0001, resp, gid, bp);
        wbuf[0] = 32'hAABB_CCDD; sbuf[0] = 4'b0101;
        axi_write(4'h1, 32'h0000_0200, 8'd0, 16'h0001, resp, gid, bp);
        axi_read(4'h0, 32'h0000_0200, 8'd0, 2'b01, 4'b1111, gid, nb);
        check_value("strb_data", rbuf[0], 32'h00BB_00DD);

        // Read with rready stalls
        axi_read(4'h3, 32'h1C00_0100, 8'd3, 2'b01, 4'b1001, gid, nb);
        check_value("stall_beats", nb, 32'd4);
        check_value("stall_rid", {28'd0, gid}, 32'h3);
        check_value("stall_d2", rbuf[2], 32'h33);
        check_value("stall_last3", {31'd0, lbuf[3]}, 32'd1);

        // Early wlast: both beats consumed, SLVERR reported
        wbuf[0] = 32'hA1; wbuf[1] = 32'hA2; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        axi_write(4'h9, 32'h0000_0500, 8'd1, 16'h0001, resp, gid, bp);
        check_value("werr_bresp", {30'd0, resp}, 32'h2);
        check_value("werr_b_prompt", {31'd0, bp}, 32'd1);
        axi_read(4'h0, 32'h0000_0500, 8'd1, 2'b01, 4'b1111, gid, nb);
        check_value("werr_d0", rbuf[0], 32'hA1);
        check_value("werr_d1", rbuf[1], 32'hA2);

        // Concurrent AR and AW in the same cycle
        wbuf[0] = 32'hCAFE_F00D; sbuf[0] = 4'hF;
        axi_write(4'h1, 32'h0000_0300, 8'd0, 16'h0001, resp, gid, bp);
        arid = 4'h1; araddr = 32'h300; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        awid = 4'h6; awaddr = 32'h400; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        check_value("conc_arready", {31'd0, arready}, 32'd1);
        check_value("conc_awready", {31'd0, awready}, 32'd1);
        step();
        arvalid = 1'b0; awvalid = 1'b0;
        check_value("conc_rvalid", {31'd0, rvalid}, 32'd1);
        check_value("conc_wready", {31'd0, wready}, 32'd1);
        check_value("conc_rdata", rdata, 32'hCAFE_F00D);
        check_value("conc_rid", {28'd0, rid}, 32'h1);
        rready = 1'b1; wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; wlast = 1'b1;
        step();
        rready = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        check_value("conc_rvalid_done", {31'd0, rvalid}, 32'd0);
        check_value("conc_bvalid", {31'd0, bvalid}, 32'd1);
        check_value("conc_bid", {28'd0, bid}, 32'h6);
        check_value("conc_bresp", {30'd0, bresp}, 32'd0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        axi_read(4'h0, 32'h0000_0400, 8'd0, 2'b01, 4'b1111, gid, nb);
        check_value("conc_wr_data", rbuf[0], 32'h1234_5678);
        axi_read(4'h0, 32'h0000_0300, 8'd0, 2'b01, 4'b1111, gid, nb);
        check_value("conc_rd_kept", rbuf[0], 32'hCAFE_F00D);

        // Reset asserted during beat 2 of a 4-beat read
        arid = 4'h7; araddr = 32'h1C00_0100; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        step();
        arvalid = 1'b0; rready = 1'b1;
        step();
        step();
        check_value("mid_rdata_b2", rdata, 32'h33);
        aresetn = 1'b0;
        #1;
        rready = 1'b0;
        check_value("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
        check_value("mid_rst_arready", {31'd0, arready}, 32'd0);
        check_value("mid_rst_rdata", rdata, 32'd0);
        repeat (2) step();
        aresetn = 1'b1;
        step();
        axi_read(4'h8, 32'h1C00_0100, 8'd0, 2'b01, 4'b1111, gid, nb);
        check_value("post_mid_data", rbuf[0], 32'h11);
        check_value("post_mid_rid", {28'd0, gid}, 32'h8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3 slave memory responder answering the CPU top's AXI master port: it accepts read bursts (cache-line refills, uncached single reads) and write bursts (cache write-backs, uncached stores) and serves them from an internal word-addressed RAM. It sits on the far side of the SoC interconnect as the simulation and FPGA memory target for the core. Read and write channels are handled by independent state machines, so one read and one write may be in flight at the same time.

## Interface
- `MEM_AW`, 16, word-address width of the internal RAM (2^MEM_AW 32-bit words)
- `READ_LAT`, 2, extra cycles between AR handshake and first R beat (used only with `AXI_SLV_READ_LAT_EN`)
- `aclk` in 1, sole clock, all logic on rising edge
- `aresetn` in 1, asynchronous active-low reset
- `arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot` in 4/32/8/3/2/2/4/3, read address; lock/cache/prot ignored
- `arvalid` in 1 / `arready` out 1, AR handshake
- `rid` out 4, `rdata` out 32, `rresp` out 2, `rlast` out 1, `rvalid` out 1 / `rready` in 1
- `awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot` in 4/32/8/3/2/2/4/3, write address; lock/cache/prot ignored
- `awvalid` in 1 / `awready` out 1
- `wid` in 4 (ignored), `wdata` in 32, `wstrb` in 4, `wlast` in 1, `wvalid` in 1 / `wready` out 1
- `bid` out 4, `bresp` out 2, `bvalid` out 1 / `bready` in 1

## Operation
- Word index = addr[MEM_AW+1:2]; upper bits alias. Data always full 32-bit word; byte lanes selected by `wstrb` on writes, size affects only address stepping.
- Beat address step: INCR (2'b01) and WRAP (2'b10) add (1<<size) per beat; FIXED (2'b00) holds address.
- Read FSM: R_IDLE → (R_WAIT) → R_DATA → R_IDLE.
  - R_IDLE: `arready`=1. On AR handshake latch id/addr/len/size/burst, beat counter=0.
  - R_WAIT (macro only): count READ_LAT cycles, then R_DATA.
  - R_DATA: `rvalid`=1, `rdata` registered word at current address, `rid`=latched id, `rresp`=2'b00, `rlast`=(counter==len). On handshake: if last → R_IDLE, else step address, counter+1, load next word.
  - `rvalid` and `rdata`/`rlast` held stable while `rready`=0.
- Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: `awready`=1; on handshake latch id/addr/len/size/burst, counter=0, error flag=0.
  - W_DATA: `wready`=1; each W handshake writes enabled bytes at current address, steps address. Burst ends on beat counter==len regardless of `wlast`; mismatch (wlast on non-final beat or absent on final beat) sets error flag.
  - W_RESP: `bvalid`=1, `bid`=latched id, `bresp`=2'b10 if error flag else 2'b00; on `bready` → W_IDLE.
- RAM: one write port, one read port. A W handshake in cycle N is visible to any `rdata` load at cycle N+1 or later; same-cycle load returns old data.
- Reset (asserted any time, including mid-burst): both FSMs to idle, counters/flags cleared immediately; RAM contents not reset. In-flight bursts are abandoned.

## Timing
- Reset values: `arready`=0, `awready`=0, `wready`=0, `rvalid`=0, `rlast`=0, `rdata`=0, `rid`=0, `rresp`=0, `bvalid`=0, `bid`=0, `bresp`=0; `arready`/`awready` rise in first cycle after deassertion.
- Read latency: AR handshake at edge T → `rvalid` at T+1 (no macro) or T+1+READ_LAT (macro). With `rready`=1 one beat per cycle; 4-beat line returns in cycles T+1..T+4.
- `arready` low from AR handshake until cycle after last R handshake: minimum one idle cycle between read bursts. Same for `awready` through B handshake.
- Write: AW at T, `wready` from T+1; B asserted cycle after final W handshake.
- Simultaneous AR and AW handshakes in the same cycle both accepted.

## Configuration
- `AXI_SLV_READ_LAT_EN`: defined → R_WAIT state inserted, first R beat delayed READ_LAT cycles (READ_LAT=0 behaves as undefined). Undefined → R_WAIT absent, first beat at T+1.

## Test plan
- Write INCR len=3 size=2 at 0x1C000100, data 0x11,0x22,0x33,0x44, wstrb 4'hF, wlast on beat 3 → bresp 2'b00, bid=awid; then read same burst → rdata 0x11..0x44, rlast only on beat 3.
- Write single 0xAABBCCDD wstrb 4'b0101 at 0x200 over prior 0x00000000 → read returns 0x00BB00DD.
- Read len=3 with `rready` toggling 1,0,0,1,... → each beat held stable while stalled, exactly 4 R handshakes, rid matches arid=4'h3.
- Write len=1 with wlast on beat 0 → two beats still consumed, bresp 2'b10.
- Concurrent AR (0x300) and AW (0x400) same cycle → both complete, read unaffected by write.
- Assert `aresetn` during beat 2 of 4-beat read → rvalid/arready 0 immediately; after release, new read of 0x1C000100 returns stored 0x11.
